// File: rtl/mdio_arbiter.sv
// ---------------------------------------------------------------------------
// mdio_arbiter
//
// Shares one MDIO master between two requesters. A requester raises reqN with
// a frame and is granted the master in round-robin order. The frame is
// checked, launched with a one-cycle mst_start pulse, and the transaction
// ends with a one-cycle ackN pulse (errN qualifies it) once the master reports
// mst_done or the wait times out.
//
// Handshake: reqN is a level request that the requester holds high, with
// frameN stable, until it sees ackN. ackN is a single-cycle pulse. errN is
// only meaningful while ackN is high. rdataN is valid from the ackN cycle of
// a successful read and holds until the next successful read by N. A reqN
// still high in the idle cycle after ackN counts as a new request.
//
// Ports
//   mdc          clock, rising edge
//   reset        asynchronous reset, active low
//   req0/1       transaction request per requester
//   frame0/1     MDIO frame per requester
//                (ST[31:30] OP[29:28] PHYAD[27:23] REGAD[22:18] TA[17:16] DATA[15:0])
//   gnt0/1       requester owns the master (START through RESP)
//   ack0/1       one-cycle completion pulse
//   err0/1       completion was a rejected frame or a timeout
//   rdata0/1     read data per requester
//   mst_start    one-cycle launch pulse to the master
//   mst_frame    frame presented to the master
//   mst_done     one-cycle completion pulse from the master
//   mst_rd_data  read data from the master, valid with mst_done
//   busy         high in every state except IDLE
//   state_dbg    current FSM state (0 IDLE, 1 START, 2 WAIT, 3 RESP)
// ---------------------------------------------------------------------------
module mdio_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        mdc,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] frame0,
    input  logic [31:0] frame1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        mst_start,
    output logic [31:0] mst_frame,
    input  logic        mst_done,
    input  logic [15:0] mst_rd_data,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter value on the last cycle of WAIT before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last;      // requester that won most recently
    logic        owner;     // requester currently being served
    logic        err_flag;  // current transaction will complete with error
    logic [7:0]  cnt;

    logic        any_req;
    logic        winner;
    logic [31:0] win_frame;
    logic        frame_ok;
    logic        timed_out;
    logic        is_read;

    // Arbitration, frame validation and next-state decode.
    always_comb begin
        any_req   = req0 | req1;
        winner    = 1'b0;
        if (req0 && req1) begin
            // Contention: whoever did not win last time goes now.
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
        win_frame = winner ? frame1 : frame0;
        frame_ok  = (win_frame[31:30] == 2'b01) &&
                    ((win_frame[29:28] == 2'b01) || (win_frame[29:28] == 2'b10));
        timed_out = (cnt == TIMEOUT_LAST);
        is_read   = (mst_frame[29:28] == 2'b10);

        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    // Bad frames skip the master and complete straight away.
                    state_nxt = frame_ok ? S_START : S_RESP;
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mst_done || timed_out) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mdc or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            err_flag  <= 1'b0;
            cnt       <= 8'd0;
            mst_frame <= 32'h0000_0000;
            rdata0    <= 16'h0000;
            rdata1    <= 16'h0000;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        last      <= winner;
                        mst_frame <= win_frame;
                        err_flag  <= ~frame_ok;
                    end
                end
                S_START: begin
                    cnt <= 8'd0;
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    // mst_done takes priority over a timeout in the same cycle.
                    if (mst_done) begin
                        err_flag <= 1'b0;
                        // Written here so rdataN is already valid during ackN.
                        if (is_read) begin
                            if (owner) begin
                                rdata1 <= mst_rd_data;
                            end else begin
                                rdata0 <= mst_rd_data;
                            end
                        end
                    end else if (timed_out) begin
                        err_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    assign busy      = (state != S_IDLE);
    assign mst_start = (state == S_START);
    assign gnt0      = busy && !owner;
    assign gnt1      = busy && owner;
    assign ack0      = (state == S_RESP) && !owner;
    assign ack1      = (state == S_RESP) && owner;
    assign err0      = ack0 && err_flag;
    assign err1      = ack1 && err_flag;
    assign state_dbg = state;

endmodule
